// File: rtl/wait_display.sv
// Queue wait-time display: counts the head-of-queue wait time down in TICK_DIV-cycle
// units and shows it as two BCD digits with seven-segment patterns plus queue status.
module wait_display #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Wtime,
  input  logic [2:0] Pcount,
  input  logic       empty_flag,
  input  logic       full_flag,
  input  logic       Hold,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units,
  output logic [1:0] status,
  output logic       hold_led,
  output logic       busy,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  state_t        state, nxt_state;
  logic [4:0]    remaining;
  logic [PW-1:0] prescaler;
  logic [7:0]    last_key;
  logic [7:0]    key;
  logic          reload, tick;

  assign key    = {Pcount, Wtime};
  assign reload = (key != last_key);
  assign tick   = (state == COUNT) && (prescaler == PS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt_state;
  end

  // Empty beats reload beats tick; a Wtime of 0 reloads straight to IDLE without expiring.
  always_comb begin
    nxt_state = state;
    if (empty_flag)  nxt_state = IDLE;
    else if (reload) nxt_state = (Wtime != 5'd0) ? COUNT : IDLE;
    else begin
      case (state)
        COUNT:   if (tick && remaining <= 5'd1) nxt_state = EXPIRE;
        EXPIRE:  nxt_state = IDLE;
        default: nxt_state = state;
      endcase
    end
  end

  always_comb begin
    busy    = (state == COUNT);
    expired = (state == EXPIRE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      prescaler <= '0;
      last_key  <= '0;
      status    <= 2'b00;
      hold_led  <= 1'b0;
    end else begin
      status   <= empty_flag ? 2'b01 : (full_flag ? 2'b10 : 2'b00);
      hold_led <= Hold;
      last_key <= key;
      if (empty_flag) begin
        remaining <= '0;
        prescaler <= '0;
      end else if (reload) begin
        remaining <= Wtime;
        prescaler <= '0;
      end else if (state == COUNT) begin
        if (tick) begin
          prescaler <= '0;
          remaining <= (remaining != 5'd0) ? remaining - 5'd1 : 5'd0;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [4:0] tens_base;

  always_comb begin
    tens      = 4'd0;
    tens_base = 5'd0;
    if (remaining >= 5'd30) begin
      tens = 4'd3; tens_base = 5'd30;
    end else if (remaining >= 5'd20) begin
      tens = 4'd2; tens_base = 5'd20;
    end else if (remaining >= 5'd10) begin
      tens = 4'd1; tens_base = 5'd10;
    end
    units     = 4'(remaining - tens_base);
    seg_units = seg7(units);
    seg_tens  = (tens == 4'd0) ? 7'h00 : seg7(tens);
  end

endmodule

// File: tb/tb_wait_display.sv
// Directed bench for wait_display at TICK_DIV=4; expected values are hand-computed.
module tb_wait_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Wtime;
  logic [2:0] Pcount;
  logic       empty_flag, full_flag, Hold;
  logic [3:0] tens, units;
  logic [6:0] seg_tens, seg_units;
  logic [1:0] status;
  logic       hold_led, busy, expired;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int exp_mark;

  wait_display #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .Wtime(Wtime), .Pcount(Pcount),
    .empty_flag(empty_flag), .full_flag(full_flag), .Hold(Hold),
    .tens(tens), .units(units), .seg_tens(seg_tens), .seg_units(seg_units),
    .status(status), .hold_led(hold_led), .busy(busy), .expired(expired)
  );

  always #5 clk = ~clk;

  // Counts cycles in which expired is high, sampled mid-cycle.
  always @(negedge clk) if (expired === 1'b1) exp_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " units"},     32'(units), 0);
    check({tag, " tens"},      32'(tens), 0);
    check({tag, " seg_units"}, 32'(seg_units), 32'h3F);
    check({tag, " seg_tens"},  32'(seg_tens), 0);
    check({tag, " status"},    32'(status), 0);
    check({tag, " hold_led"},  32'(hold_led), 0);
    check({tag, " busy"},      32'(busy), 0);
    check({tag, " expired"},   32'(expired), 0);
  endtask

  initial begin
    // Reset held with arbitrary inputs
    reset = 1'b0; Pcount = 3'd3; Wtime = 5'd17; empty_flag = 1'b0; full_flag = 1'b1; Hold = 1'b1;
    step(3);
    check_reset_vals("rst");
    check("rst exp_cnt", 32'(exp_cnt), 0);

    Pcount = 3'd0; Wtime = 5'd0; full_flag = 1'b0; Hold = 1'b0;
    reset = 1'b1;
    step(2);
    check("idle units", 32'(units), 0);

    // Wtime=3 countdown
    Pcount = 3'd1; Wtime = 5'd3;
    step(1);
    check("w3 load units", 32'(units), 3);
    check("w3 load busy", 32'(busy), 1);
    step(3);
    check("w3 +3 units", 32'(units), 3);
    step(1);
    check("w3 +4 units", 32'(units), 2);
    step(4);
    check("w3 +8 units", 32'(units), 1);
    step(4);
    check("w3 +12 units", 32'(units), 0);
    check("w3 +12 busy", 32'(busy), 0);
    check("w3 +12 expired", 32'(expired), 1);
    step(1);
    check("w3 +13 expired", 32'(expired), 0);
    check("w3 +13 busy", 32'(busy), 0);
    step(4);
    check("w3 idle units", 32'(units), 0);
    check("w3 exp_cnt", 32'(exp_cnt), 1);

    // Wtime=25 two-digit display
    Pcount = 3'd5; Wtime = 5'd25;
    step(1);
    check("w25 tens", 32'(tens), 2);
    check("w25 seg_tens", 32'(seg_tens), 32'h5B);
    check("w25 units", 32'(units), 5);
    check("w25 seg_units", 32'(seg_units), 32'h6D);
    step(4);
    check("w25 +4 units", 32'(units), 4);
    check("w25 +4 seg_units", 32'(seg_units), 32'h66);
    step(88);
    check("w25 rem2 units", 32'(units), 2);
    check("w25 rem2 seg_tens", 32'(seg_tens), 0);
    check("w25 rem2 seg_units", 32'(seg_units), 32'h5B);

    // Reload mid-count with prescaler part-way
    step(2);
    exp_mark = exp_cnt;
    Pcount = 3'd2; Wtime = 5'd7;
    step(1);
    check("rl units", 32'(units), 7);
    check("rl busy", 32'(busy), 1);
    step(3);
    check("rl +3 units", 32'(units), 7);
    step(1);
    check("rl +4 units", 32'(units), 6);
    check("rl no expire", 32'(exp_cnt), 32'(exp_mark));

    // Empty mid-count
    step(2);
    empty_flag = 1'b1;
    step(1);
    check("emp units", 32'(units), 0);
    check("emp status", 32'(status), 1);
    check("emp busy", 32'(busy), 0);
    check("emp expired", 32'(expired), 0);
    step(2);
    empty_flag = 1'b0;
    step(2);
    check("emp rel units", 32'(units), 0);
    check("emp rel busy", 32'(busy), 0);
    check("emp no expire", 32'(exp_cnt), 32'(exp_mark));

    // Full and Hold do not affect the countdown
    Pcount = 3'd4; Wtime = 5'd12; full_flag = 1'b1; Hold = 1'b1;
    step(1);
    check("full status", 32'(status), 2);
    check("full hold_led", 32'(hold_led), 1);
    check("full tens", 32'(tens), 1);
    check("full units", 32'(units), 2);
    check("full busy", 32'(busy), 1);
    step(4);
    check("full +4 units", 32'(units), 1);
    Hold = 1'b0;
    step(1);
    check("hold_led clr", 32'(hold_led), 0);

    // Reset pulse at remaining=9
    full_flag = 1'b0; Pcount = 3'd3; Wtime = 5'd9;
    step(1);
    check("r9 units", 32'(units), 9);
    step(2);
    exp_mark = exp_cnt;
    reset = 1'b0;
    #1;
    check_reset_vals("r9 async");
    step(2);
    check("r9 held units", 32'(units), 0);
    reset = 1'b1;
    step(1);
    check("r9 reload units", 32'(units), 9);
    check("r9 reload busy", 32'(busy), 1);
    step(4);
    check("r9 +4 units", 32'(units), 8);
    check("r9 no expire", 32'(exp_cnt), 32'(exp_mark));

    // Empty wins over full
    empty_flag = 1'b1; full_flag = 1'b1;
    step(1);
    check("both status", 32'(status), 1);
    empty_flag = 1'b0; full_flag = 1'b0;

    // Maximum wait time
    Wtime = 5'd31;
    step(1);
    check("w31 tens", 32'(tens), 3);
    check("w31 seg_tens", 32'(seg_tens), 32'h4F);
    check("w31 units", 32'(units), 1);
    check("w31 seg_units", 32'(seg_units), 32'h06);

    // Reload to zero goes idle without expiring
    Wtime = 5'd0;
    step(1);
    check("w0 busy", 32'(busy), 0);
    check("w0 units", 32'(units), 0);
    check("w0 expired", 32'(expired), 0);
    step(2);
    check("total exp_cnt", 32'(exp_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
